mem_port_arbiter: RTL and testbench

Parametrised N-channel memory arbiter that merges the CPU core's separate requestor ports (instruction fetch, data load/store, future DMA/debug) onto one shared memory bus using the rv32i read/write/resp handshake. Sits between the core and the unified memory or L2 in the next-generation top level. Supports round-robin or fixed-priority selection and registers the granted request, so memory-side outputs are glitch-free and held stable.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/rr_picker.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Channel index width; a single channel still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requestor-side and memory-side bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_address;
    logic [NUM_CH-1:0]                 ch_read;
    logic [NUM_CH-1:0]                 ch_write;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0][BE_WIDTH-1:0]   ch_byte_enable;
    logic [DATA_WIDTH-1:0]             ch_rdata;
    logic [NUM_CH-1:0]                 ch_resp;

    logic [ADDR_WIDTH-1:0]             mem_address;
    logic                              mem_read;
    logic                              mem_write;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic [BE_WIDTH-1:0]               mem_byte_enable;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              mem_resp;

    // Arbiter view
    modport slave (
        input  ch_address, ch_read, ch_write, ch_wdata, ch_byte_enable,
        input  mem_rdata, mem_resp,
        output ch_rdata, ch_resp,
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );

    // Requestors plus memory view
    modport master (
        output ch_address, ch_read, ch_write, ch_wdata, ch_byte_enable,
        output mem_rdata, mem_resp,
        input  ch_rdata, ch_resp,
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin after last_grant, or lowest index.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    input  logic              mode,
    output logic [IDX_W-1:0]  winner_idx,
    output logic              any_req
);

    logic        found;
    int unsigned cand;

    // Wrap uses a compare so non-power-of-two channel counts stay in range.
    always_comb begin
        winner_idx = '0;
        any_req    = |req;
        found      = 1'b0;
        cand       = 0;
        if (mode == 1'(ARB_FIXED)) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!found && req[IDX_W'(i)]) begin
                    winner_idx = IDX_W'(i);
                    found      = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                cand = 32'(last_grant) + k;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                if (!found && req[IDX_W'(cand)]) begin
                    winner_idx = IDX_W'(cand);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging requestor ports onto one read/write/resp memory bus.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARB_MODE   = ARB_RR
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W      = idx_width(NUM_CH);
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic        MODE_FIXED = (ARB_MODE == ARB_FIXED);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;

    logic [NUM_CH-1:0]     req;
    logic [IDX_W-1:0]      winner_idx;
    logic                  any_req;
    mem_op_t               op_c;

    assign req = bus.ch_read | bus.ch_write;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_q),
        .mode       (MODE_FIXED),
        .winner_idx (winner_idx),
        .any_req    (any_req)
    );

    // Next state: latch the winner in IDLE, hold everything in BUSY until mem_resp.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        op_c    = bus.ch_write[winner_idx] ? OP_WRITE : OP_READ;
        case (state_q)
            IDLE: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (any_req) begin
                    grant_d = winner_idx;
                    last_d  = winner_idx;
                    addr_d  = bus.ch_address[winner_idx];
                    wdata_d = bus.ch_wdata[winner_idx];
                    be_d    = bus.ch_byte_enable[winner_idx];
                    rd_d    = (op_c == OP_READ);
                    wr_d    = (op_c == OP_WRITE);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Completion is routed back in the mem_resp cycle; IDLE-state resp is dropped.
    always_comb begin
        bus.ch_resp = '0;
        if ((state_q == BUSY) && bus.mem_resp) begin
            bus.ch_resp[grant_q] = 1'b1;
        end
    end

    assign bus.ch_rdata        = bus.mem_rdata;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_read        = rd_q;
    assign bus.mem_write       = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-channel round-robin and a 3-channel fixed-priority arbiter.
module tb_mem_port_arbiter;

    typedef struct {
        int          s;
        int          ch;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ia ();
    mem_port_arbiter_if #(.NUM_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ib ();

    mem_port_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    mem_port_arbiter #(.NUM_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic g_rd(input int s);
        return (s == 0) ? ia.mem_read : ib.mem_read;
    endfunction
    function automatic logic g_wr(input int s);
        return (s == 0) ? ia.mem_write : ib.mem_write;
    endfunction
    function automatic logic [31:0] g_addr(input int s);
        return (s == 0) ? ia.mem_address : ib.mem_address;
    endfunction
    function automatic logic [31:0] g_wdata(input int s);
        return (s == 0) ? ia.mem_wdata : ib.mem_wdata;
    endfunction
    function automatic logic [3:0] g_be(input int s);
        return (s == 0) ? ia.mem_byte_enable : ib.mem_byte_enable;
    endfunction
    function automatic logic [31:0] g_rdata(input int s);
        return (s == 0) ? ia.ch_rdata : ib.ch_rdata;
    endfunction
    function automatic logic [3:0] g_resp(input int s);
        return (s == 0) ? {2'b00, ia.ch_resp} : {1'b0, ib.ch_resp};
    endfunction

    task automatic clear_all();
        ia.ch_read = '0; ia.ch_write = '0; ia.ch_address = '0; ia.ch_wdata = '0;
        ia.ch_byte_enable = '0; ia.mem_rdata = '0; ia.mem_resp = 1'b0;
        ib.ch_read = '0; ib.ch_write = '0; ib.ch_address = '0; ib.ch_wdata = '0;
        ib.ch_byte_enable = '0; ib.mem_rdata = '0; ib.mem_resp = 1'b0;
    endtask

    task automatic set_req(input int s, input int ch, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (s == 0) begin
            ia.ch_read[1'(ch)] = rd; ia.ch_write[1'(ch)] = wr; ia.ch_address[1'(ch)] = addr;
            ia.ch_wdata[1'(ch)] = wdata; ia.ch_byte_enable[1'(ch)] = be;
        end else begin
            ib.ch_read[2'(ch)] = rd; ib.ch_write[2'(ch)] = wr; ib.ch_address[2'(ch)] = addr;
            ib.ch_wdata[2'(ch)] = wdata; ib.ch_byte_enable[2'(ch)] = be;
        end
    endtask

    task automatic drop_req(input int s, input int ch);
        if (s == 0) begin
            ia.ch_read[1'(ch)] = 1'b0; ia.ch_write[1'(ch)] = 1'b0;
        end else begin
            ib.ch_read[2'(ch)] = 1'b0; ib.ch_write[2'(ch)] = 1'b0;
        end
    endtask

    task automatic set_mem(input int s, input logic resp, input logic [31:0] rdata);
        if (s == 0) begin
            ia.mem_resp = resp; ia.mem_rdata = rdata;
        end else begin
            ib.mem_resp = resp; ib.mem_rdata = rdata;
        end
    endtask

    task automatic expect_tx(input int s, input int ch, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        sb.push_back('{s: s, ch: ch, wr: wr, addr: addr, wdata: wdata, be: be});
    endtask

    task automatic chk_zero(input int s, input string tag);
        chk({tag, "_mem_read"}, 64'(g_rd(s)), 64'(0));
        chk({tag, "_mem_write"}, 64'(g_wr(s)), 64'(0));
        chk({tag, "_mem_address"}, 64'(g_addr(s)), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(g_wdata(s)), 64'(0));
        chk({tag, "_mem_be"}, 64'(g_be(s)), 64'(0));
        chk({tag, "_ch_resp"}, 64'(g_resp(s)), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_all();
        rst = 1'b1;
        #2;
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Memory model side: wait for the next strobe, match against the scoreboard, respond.
    task automatic serve(input logic [31:0] rdata, input int lat, input bit keep);
        exp_t e;
        int   cyc;
        if (sb.size() == 0) begin
            $display("FAIL sb_empty: observed no expected transaction, expected one queued");
            $fatal(1, "scoreboard empty");
        end
        e   = sb.pop_front();
        cyc = 0;
        while (!(g_rd(e.s) | g_wr(e.s)) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_seen", 64'(cyc < 20), 64'(1));
        if (cyc >= 20) return;
        chk("mem_write", 64'(g_wr(e.s)), 64'(e.wr));
        chk("mem_read", 64'(g_rd(e.s)), 64'(!e.wr));
        chk("mem_address", 64'(g_addr(e.s)), 64'(e.addr));
        if (e.wr) begin
            chk("mem_wdata", 64'(g_wdata(e.s)), 64'(e.wdata));
            chk("mem_be", 64'(g_be(e.s)), 64'(e.be));
        end
        repeat (lat - 1) @(negedge clk);
        chk("hold_address", 64'(g_addr(e.s)), 64'(e.addr));
        set_mem(e.s, 1'b1, rdata);
        #1;
        chk("ch_resp", 64'(g_resp(e.s)), 64'(4'(1 << e.ch)));
        chk("ch_rdata", 64'(g_rdata(e.s)), 64'(rdata));
        @(negedge clk);
        chk("strobe_drop", 64'(g_rd(e.s) | g_wr(e.s)), 64'(0));
        set_mem(e.s, 1'b0, 32'h0);
        if (!keep) drop_req(e.s, e.ch);
    endtask

    initial begin
        clear_all();
        // Asynchronous reset assert and release, no clock edge involved
        #1 rst = 1'b1;
        #1;
        chk_zero(0, "por_a");
        chk_zero(1, "por_b");
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero(0, "idle_a");

        // Single read, 3-cycle memory latency
        expect_tx(0, 0, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
        set_req(0, 0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_mem_read", 64'(ia.mem_read), 64'(1));
        chk("t1_mem_address", 64'(ia.mem_address), 64'(32'h60));
        serve(32'hDEAD_BEEF, 3, 1'b0);

        // Round-robin contention from reset: ch0, ch1, then ch0 again
        do_reset();
        expect_tx(0, 0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        expect_tx(0, 1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        set_req(0, 0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        set_req(0, 1, 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        serve(32'h0A0A_0A0A, 2, 1'b0);
        serve(32'h0000_0000, 1, 1'b0);
        expect_tx(0, 0, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
        expect_tx(0, 1, 1'b1, 32'h0000_0104, 32'h9ABC_DEF0, 4'b1100);
        set_req(0, 0, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
        set_req(0, 1, 1'b0, 1'b1, 32'h0000_0104, 32'h9ABC_DEF0, 4'b1100);
        serve(32'h1111_2222, 1, 1'b0);
        serve(32'h3333_4444, 2, 1'b0);

        // Fixed priority on 3 channels: ch1 wins while it keeps requesting
        expect_tx(1, 1, 1'b0, 32'h0000_0011, 32'h0, 4'h0);
        expect_tx(1, 1, 1'b0, 32'h0000_0011, 32'h0, 4'h0);
        expect_tx(1, 1, 1'b0, 32'h0000_0011, 32'h0, 4'h0);
        expect_tx(1, 2, 1'b0, 32'h0000_0022, 32'h0, 4'h0);
        set_req(1, 1, 1'b1, 1'b0, 32'h0000_0011, 32'h0, 4'h0);
        set_req(1, 2, 1'b1, 1'b0, 32'h0000_0022, 32'h0, 4'h0);
        serve(32'hB100_0001, 2, 1'b1);
        serve(32'hB100_0002, 1, 1'b1);
        serve(32'hB100_0003, 2, 1'b0);
        serve(32'hB200_0001, 1, 1'b0);

        // Read and write together: write wins
        expect_tx(0, 1, 1'b1, 32'h0000_0140, 32'hCAFE_F00D, 4'hF);
        set_req(0, 1, 1'b1, 1'b1, 32'h0000_0140, 32'hCAFE_F00D, 4'hF);
        serve(32'h5555_5555, 2, 1'b0);

        // mem_resp while IDLE produces no completion
        set_mem(0, 1'b1, 32'h0000_0077);
        #1;
        chk("idle_resp_ch_resp", 64'(ia.ch_resp), 64'(0));
        chk("idle_resp_ch_rdata", 64'(ia.ch_rdata), 64'(32'h77));
        @(negedge clk);
        chk("idle_resp_no_strobe", 64'(ia.mem_read | ia.mem_write), 64'(0));
        set_mem(0, 1'b0, 32'h0);

        // Reset two cycles into a write; held requests restart from ch0
        do_reset();
        set_req(0, 0, 1'b0, 1'b1, 32'h0000_0300, 32'hAAAA_0000, 4'hF);
        @(negedge clk);
        chk("rst_busy_mem_write", 64'(ia.mem_write), 64'(1));
        @(negedge clk);
        set_req(0, 1, 1'b0, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'hC);
        set_mem(0, 1'b1, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_write_drop", 64'(ia.mem_write), 64'(0));
        chk("rst_busy_ch_resp", 64'(ia.ch_resp), 64'(0));
        chk("rst_busy_address", 64'(ia.mem_address), 64'(0));
        set_mem(0, 1'b0, 32'h0);
        #3 rst = 1'b0;
        expect_tx(0, 0, 1'b1, 32'h0000_0300, 32'hAAAA_0000, 4'hF);
        expect_tx(0, 1, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'hC);
        serve(32'h0, 2, 1'b0);
        serve(32'h0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
